// File: rtl/uart_pkg.sv
// Shared definitions for the UART: FSM state encoding used by both the
// receiver and the transmitter, and the clocks-per-bit calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Integer-truncated number of clock cycles per serial bit
  function automatic int clksPerBit(input int fMHz, input int fBaud);
    return (fMHz * 1000000) / fBaud;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: sends start bit, n data bits LSB first, stop bit.
// send_req marks the first cycle of the start bit and send_ack the last
// cycle of the stop bit; idle_o tells the owner a new byte may be started.
module uart_tx
  import uart_pkg::*;
#(
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [n-1:0] data_i,
  output logic         tx_o,
  output logic         idle_o,
  output logic         sendReq_o,
  output logic         sendAck_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(n - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bitIdx_q, bitIdx_d;
  logic [n-1:0]  shift_q, shift_d;

  // State, bit timer, bit index and shift register; reset aborts any frame
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
    end
  end

  // Next-state logic: each frame slot lasts exactly CLKS_PER_BIT cycles
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = START;
          cnt_d   = '0;
          shift_d = data_i;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = DATA;
          cnt_d    = '0;
          bitIdx_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bitIdx_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign tx_o      = (state_q == START) ? 1'b0 :
                     (state_q == DATA)  ? shift_q[0] : 1'b1;
  assign idle_o    = (state_q == IDLE);
  assign sendReq_o = (state_q == START) && (cnt_q == '0);
  assign sendAck_o = (state_q == STOP) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart.sv
// UART loopback top: inline receiver and one-byte pending slot feeding the
// uart_tx transmitter. Every correctly framed byte is echoed on TX.
// Optional build macro UART_RX_SYNC_EN inserts a two-flop RX synchronizer.
// Note: rst_n is an active-high asynchronous reset despite its name.
module uart
  import uart_pkg::*;
#(
  parameter int n      = 8,
  parameter int f_MHz  = 50,
  parameter int f_baud = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic RX,
  output logic recv_req,
  output logic send_req,
  output logic TX,
  output logic send_ack
);

  localparam int CPB = clksPerBit(f_MHz, f_baud);
  localparam int CW  = $clog2(CPB + 1);
  localparam int BW  = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(n - 1);

  logic rxS;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rxSync_q;

  // Two-flop synchronizer, resets to the idle line level
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) rxSync_q <= 2'b11;
    else       rxSync_q <= {rxSync_q[0], RX};
  end

  assign rxS = rxSync_q[1];
`else
  assign rxS = RX;
`endif

  uart_state_e   rxState_q, rxState_d;
  logic [CW-1:0] rxCnt_q, rxCnt_d;
  logic [BW-1:0] rxBit_q, rxBit_d;
  logic [n-1:0]  rxShift_q, rxShift_d;
  logic          rxErr_q, rxErr_d;
  logic          accept;
  logic          recvReq_q;
  logic          pendValid_q, pendValid_d;
  logic [n-1:0]  pendData_q, pendData_d;
  logic          txIdle;
  logic          take;

  // Receiver state, pending slot and the registered recv_req pulse
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rxState_q   <= IDLE;
      rxCnt_q     <= '0;
      rxBit_q     <= '0;
      rxShift_q   <= '0;
      rxErr_q     <= 1'b0;
      recvReq_q   <= 1'b0;
      pendValid_q <= 1'b0;
      pendData_q  <= '0;
    end else begin
      rxState_q   <= rxState_d;
      rxCnt_q     <= rxCnt_d;
      rxBit_q     <= rxBit_d;
      rxShift_q   <= rxShift_d;
      rxErr_q     <= rxErr_d;
      recvReq_q   <= accept;
      pendValid_q <= pendValid_d;
      pendData_q  <= pendData_d;
    end
  end

  // Receiver: confirm start at half a bit, then sample each bit centre;
  // a low stop bit discards the byte and waits for the line to go idle
  always_comb begin
    rxState_d = rxState_q;
    rxCnt_d   = rxCnt_q;
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    rxErr_d   = rxErr_q;
    accept    = 1'b0;
    unique case (rxState_q)
      IDLE: begin
        if (!rxS) begin
          rxState_d = START;
          rxCnt_d   = '0;
        end
      end
      START: begin
        if (rxCnt_q == HALF_LAST) begin
          rxCnt_d   = '0;
          rxBit_d   = '0;
          rxState_d = rxS ? IDLE : DATA;
        end else begin
          rxCnt_d = rxCnt_q + CW'(1);
        end
      end
      DATA: begin
        if (rxCnt_q == CNT_LAST) begin
          rxCnt_d   = '0;
          rxShift_d = {rxS, rxShift_q[n-1:1]};
          if (rxBit_q == BIT_LAST) begin
            rxState_d = STOP;
          end else begin
            rxBit_d = rxBit_q + BW'(1);
          end
        end else begin
          rxCnt_d = rxCnt_q + CW'(1);
        end
      end
      STOP: begin
        if (rxErr_q) begin
          if (rxS) begin
            rxState_d = IDLE;
            rxErr_d   = 1'b0;
          end
        end else if (rxCnt_q == CNT_LAST) begin
          rxCnt_d = '0;
          if (rxS) begin
            accept    = 1'b1;
            rxState_d = IDLE;
          end else begin
            rxErr_d = 1'b1;
          end
        end else begin
          rxCnt_d = rxCnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign take = pendValid_q & txIdle;

  // Pending slot: emptied when the transmitter picks it up, filled by an
  // accepted byte unless still occupied (then the new byte is dropped)
  always_comb begin
    pendValid_d = pendValid_q;
    pendData_d  = pendData_q;
    if (take) pendValid_d = 1'b0;
    if (accept && (!pendValid_q || take)) begin
      pendValid_d = 1'b1;
      pendData_d  = rxShift_q;
    end
  end

  assign recv_req = recvReq_q;

  uart_tx #(
    .n            (n),
    .CLKS_PER_BIT (CPB)
  ) u_tx (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .start_i   (pendValid_q),
    .data_i    (pendData_q),
    .tx_o      (TX),
    .idle_o    (txIdle),
    .sendReq_o (send_req),
    .sendAck_o (send_ack)
  );

endmodule

// File: tb/tb_uart.sv
`timescale 1ns/1ps
module tb_uart;

  localparam int CPB = (50 * 1000000) / 115200;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // stop bit is sampled 9.5 bit times after the start edge; recv_req is
  // visible in the cycle after that sampling edge
  localparam int RECV_LAT = (19 * CPB) / 2 + 1 + SYNC_LAT;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic RX    = 1'b1;
  logic recv_req, send_req, TX, send_ack;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int recvCount = 0, sendReqCount = 0, ackCount = 0, txLowCount = 0;
  int lastRecvCyc = 0, lastSendReqCyc = 0, lastAckCyc = 0;
  int echoCount = 0, pushedCount = 0;
  logic [7:0] expQ[$];

  uart #(.n(8), .f_MHz(50), .f_baud(115200)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .recv_req (recv_req),
    .send_req (send_req),
    .TX       (TX),
    .send_ack (send_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse counters and timestamps, sampled away from the active edge
  always @(negedge clk) begin
    if (recv_req === 1'b1) begin recvCount++; lastRecvCyc = cyc; end
    if (send_req === 1'b1) begin sendReqCount++; lastSendReqCyc = cyc; end
    if (send_ack === 1'b1) begin ackCount++; lastAckCyc = cyc; end
    if (TX === 1'b0) txLowCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // drive the first 'slots' slots of a frame (start, 8 data LSB first, stop)
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int slots);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    for (int k = 0; k < slots; k++) begin
      RX = frame[k];
      repeat (CPB) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic pushExpected(input logic [7:0] b);
    expQ.push_back(b);
    pushedCount++;
  endtask

  task automatic waitAcks(input string tag, input int target, input int budget);
    int left;
    left = budget;
    while (ackCount < target && left > 0) begin
      @(negedge clk);
      left--;
    end
    #1;
    checkOutput(tag, (ackCount >= target), 1);
  endtask

  task automatic decWait(input int k, output bit hit);
    hit = 1'b0;
    repeat (k) begin
      @(negedge clk);
      if (rst_n) hit = 1'b1;
    end
  endtask

  // TX line decoder: samples bit centres and compares with expected bytes
  initial begin : txDecoder
    logic [7:0] got;
    logic [7:0] exp;
    bit hit;
    forever begin
      @(negedge clk);
      if (!rst_n && TX === 1'b0) begin
        got = '0;
        decWait(CPB / 2, hit);
        if (!hit) checkOutput("txStartMid", TX, 1'b0);
        for (int i = 0; i < 8; i++) begin
          if (!hit) begin
            decWait(CPB, hit);
            got[i] = TX;
          end
        end
        if (!hit) decWait(CPB, hit);
        if (!hit) begin
          checkOutput("txStopBit", TX, 1'b1);
          checkOutput("echoQueued", (expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkOutput("echoByte", got, exp);
          end
          echoCount++;
        end
      end
    end
  end

  initial begin : stimulus
    int baseRecv, baseReq, baseAck, baseLow, startCyc;
    logic [7:0] b1, b2;
    int gap;

    // reset values
    repeat (5) @(negedge clk);
    #1;
    checkOutput("resetTX", TX, 1'b1);
    checkOutput("resetRecvReq", recv_req, 1'b0);
    checkOutput("resetSendReq", send_req, 1'b0);
    checkOutput("resetSendAck", send_ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (CPB) @(negedge clk);

    // 0xA5: latency, send_req next cycle, send_ack after 10 bit times
    baseRecv = recvCount; baseAck = ackCount;
    pushExpected(8'hA5);
    startCyc = cyc;
    applyStimulus(8'hA5, 1'b1, 10);
    waitAcks("ackA5", baseAck + 1, 12 * CPB);
    checkOutput("recvA5Count", recvCount - baseRecv, 1);
    checkOutput("recvLatency", lastRecvCyc - startCyc, RECV_LAT);
    checkOutput("sendReqAfterRecv", lastSendReqCyc - lastRecvCyc, 1);
    checkOutput("ackAfterSendReq", lastAckCyc - lastSendReqCyc, 10 * CPB - 1);

    // glitch: 100 low clocks must be rejected
    @(negedge clk);
    baseRecv = recvCount; baseReq = sendReqCount; baseLow = txLowCount;
    RX = 1'b0;
    repeat (100) @(negedge clk);
    RX = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    #1;
    checkOutput("glitchRecv", recvCount - baseRecv, 0);
    checkOutput("glitchSendReq", sendReqCount - baseReq, 0);
    checkOutput("glitchTxLow", txLowCount - baseLow, 0);

    // framing error 0x3C, then valid 0x81
    @(negedge clk);
    baseRecv = recvCount; baseReq = sendReqCount;
    applyStimulus(8'h3C, 1'b0, 10);
    repeat (CPB) @(negedge clk);
    #1;
    checkOutput("frameErrRecv", recvCount - baseRecv, 0);
    checkOutput("frameErrSendReq", sendReqCount - baseReq, 0);
    baseAck = ackCount;
    pushExpected(8'h81);
    applyStimulus(8'h81, 1'b1, 10);
    waitAcks("ack81", baseAck + 1, 12 * CPB);
    checkOutput("recv81Count", recvCount - baseRecv, 1);

    // back-to-back 0x00 and 0xFF with one idle bit between
    @(negedge clk);
    baseRecv = recvCount; baseAck = ackCount;
    pushExpected(8'h00);
    pushExpected(8'hFF);
    applyStimulus(8'h00, 1'b1, 10);
    repeat (CPB) @(negedge clk);
    applyStimulus(8'hFF, 1'b1, 10);
    waitAcks("ackPair", baseAck + 2, 12 * CPB);
    checkOutput("recvPairCount", recvCount - baseRecv, 2);
    checkOutput("ackPairCount", ackCount - baseAck, 2);

    // reset mid-DATA on both RX and TX (echo of 0x00 is driving a 0 bit)
    @(negedge clk);
    applyStimulus(8'h00, 1'b1, 10);
    b1 = 8'($urandom_range(0, 255));
    applyStimulus(b1, 1'b1, 4);
    #1;
    checkOutput("txLowBeforeReset", TX, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midResetTX", TX, 1'b1);
    checkOutput("midResetRecvReq", recv_req, 1'b0);
    checkOutput("midResetSendReq", send_req, 1'b0);
    checkOutput("midResetSendAck", send_ack, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    baseRecv = recvCount; baseReq = sendReqCount; baseAck = ackCount;
    repeat (2 * CPB) @(negedge clk);
    #1;
    checkOutput("postResetRecv", recvCount - baseRecv, 0);
    checkOutput("postResetSendReq", sendReqCount - baseReq, 0);
    pushExpected(8'h55);
    applyStimulus(8'h55, 1'b1, 10);
    waitAcks("ack55", baseAck + 1, 12 * CPB);
    checkOutput("recv55Count", recvCount - baseRecv, 1);

    // random bytes with random idle gaps of 1..2 bit times
    @(negedge clk);
    baseRecv = recvCount; baseAck = ackCount;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    gap = $urandom_range(1, 2);
    pushExpected(b1);
    pushExpected(b2);
    applyStimulus(b1, 1'b1, 10);
    repeat (gap * CPB) @(negedge clk);
    applyStimulus(b2, 1'b1, 10);
    waitAcks("ackRandom", baseAck + 2, 12 * CPB);
    checkOutput("recvRandomCount", recvCount - baseRecv, 2);

    // every expected byte must have been echoed
    repeat (CPB) @(negedge clk);
    #1;
    checkOutput("queueEmpty", expQ.size(), 0);
    checkOutput("echoCount", echoCount, pushedCount);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 SHALL have parameter n, default 8: data bits per frame.
REQ-002 SHALL have parameter f_MHz, default 50: clock frequency in MHz.
REQ-003 SHALL have parameter f_baud, default 115200: baud rate.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-high reset; asserted when 1, despite the suffix.
REQ-006 SHALL have port RX, input, 1: serial receive line, idle high.
REQ-007 SHALL have port recv_req, output, 1: one-cycle pulse when a valid frame has been received.
REQ-008 SHALL have port send_req, output, 1: one-cycle pulse when the transmitter starts a frame.
REQ-009 SHALL have port TX, output, 1: serial transmit line, idle high.
REQ-010 SHALL have port send_ack, output, 1: one-cycle pulse when a transmitted frame's stop bit completes.

Function
REQ-011 SHALL use CLKS_PER_BIT = f_MHz*1000000/f_baud, integer-truncated (434 at defaults).
REQ-012 SHALL use frame format 1 start bit (0), n data bits LSB first, 1 stop bit (1), no parity.
REQ-013 SHALL implement RX FSM states IDLE, START, DATA, STOP.
- IDLE -> START on RX low.
- START: at CLKS_PER_BIT/2, RX low -> DATA, RX high -> IDLE (glitch rejected).
- DATA: sample every CLKS_PER_BIT, bit index 0..n-1.
- STOP: sample after CLKS_PER_BIT.
REQ-014 SHALL handle the stop sample as follows:
- RX=1: latch the byte and pulse recv_req for exactly one cycle in that cycle.
- RX=0: framing error; discard the byte, no pulse, and stay in STOP until RX=1, then go to IDLE.
REQ-015 SHALL loop back every received byte: the byte accepted with recv_req is transmitted on TX.
REQ-016 SHALL implement TX FSM states IDLE, START, DATA, STOP, one bit per CLKS_PER_BIT.
- TX=1 in IDLE and STOP.
REQ-017 SHALL start a frame from TX IDLE with a pending byte: the cycle after recv_req, pulse send_req for one cycle and drive the start bit.
REQ-018 SHALL pulse send_ack for one cycle on the last cycle of the stop bit, then return to IDLE; a pending byte starts on the next cycle.
REQ-019 SHALL hold one pending byte while TX is busy; a new byte arriving while the pending slot is full is dropped.
REQ-020 SHALL accept simultaneous recv_req and send_ack: the byte is queued without loss.
REQ-021 SHALL run RX and TX fully independently (full duplex).

Reset
REQ-022 SHALL, while rst_n=1, force TX=1, recv_req=0, send_req=0, send_ack=0, both FSMs to IDLE, counters to 0, and the pending slot to empty.
REQ-023 SHALL abort any frame on reset mid-operation; after release, RX waits for the next falling edge.

Configuration
REQ-024 SHALL, when UART_RX_SYNC_EN is defined, pass RX through a two-flop synchronizer (reset value 1) before the RX FSM, adding 2 cycles of latency to all RX timing.
REQ-025 SHALL, when UART_RX_SYNC_EN is undefined, sample RX directly; the rest of the behaviour is identical.

Structure
REQ-026 SHALL place the RX/TX state enum typedef and a CLKS_PER_BIT calculation function/constant in the shared package uart_pkg.
REQ-027 SHALL implement the transmitter as sub-module uart_tx, instantiated once in uart, with the receiver and pending buffer inline.

Verification
REQ-028 Frame 0xA5 on RX at 434 clocks/bit -> recv_req pulse once, 9.5 bit times (about 4123 clocks) after the start edge; send_req next cycle; TX carries 0,1,0,1,0,0,1,0,1,1; send_ack after 10 bit times.
REQ-029 RX low for 100 clocks then high -> no recv_req, TX stays 1.
REQ-030 Frame 0x3C with stop bit 0 -> no recv_req, no send_req; next valid frame 0x81 is received and echoed correctly.
REQ-031 Two back-to-back frames 0x00 and 0xFF with 1 idle bit between -> two recv_req pulses, both bytes echoed in order, two send_ack pulses.
REQ-032 rst_n asserted mid-DATA on both RX and TX -> all outputs return to reset values immediately; the following frame 0x55 is received and echoed.
REQ-033 Build with UART_RX_SYNC_EN -> recv_req timing of REQ-028 shifted by exactly 2 cycles.
